lsu_bus_ctrl: RTL and testbench

- Sequential load/store bus controller for the SRV1 memory stage.
- Consumes the store data and byte mask produced by the store endian-adjust stage.
- Issues a single-outstanding request/acknowledge transaction on the big-endian data bus.
- For loads, extracts, byte-swaps to little-endian and sign- or zero-extends the returned word before handing it to writeback.

---
 rtl/srv1_lsu_pkg.sv | 45 ++++
 rtl/lsu_bus_ctrl_load_adj.sv | 35 +++
 rtl/lsu_bus_ctrl.sv | 144 ++++++++++++++
 tb/tb_lsu_bus_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/srv1_lsu_pkg.sv
// Shared types, funct3 encodings and byte-lane helpers for the SRV1 load/store unit.
// Lane order throughout: mask bit3 = bus byte 0 (bits 31:24).
package srv1_lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [2:0] FN3_B  = 3'd0;
   localparam logic [2:0] FN3_H  = 3'd1;
   localparam logic [2:0] FN3_W  = 3'd2;
   localparam logic [2:0] FN3_BU = 3'd4;
   localparam logic [2:0] FN3_HU = 3'd5;

   localparam logic [3:0] BE_NONE    = 4'b0000;
   localparam logic [3:0] BE_ALL     = 4'b1111;
   localparam logic [3:0] BE_BYTE0   = 4'b1000;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;

   // Illegal funct3 encodings are folded into the misaligned path.
   function automatic logic is_misaligned(input logic [2:0] fn3, input logic [1:0] a);
      logic mis;
      case (fn3)
         FN3_B, FN3_BU: mis = 1'b0;
         FN3_H, FN3_HU: mis = a[0];
         FN3_W:         mis = (a != 2'b00);
         default:       mis = 1'b1;
      endcase
      return mis;
   endfunction

   function automatic logic [3:0] load_be(input logic [2:0] fn3, input logic [1:0] a);
      logic [3:0] be;
      case (fn3[1:0])
         2'd0:    be = BE_BYTE0 >> a;
         2'd1:    be = a[1] ? BE_HALF_LO : BE_HALF_HI;
         default: be = BE_ALL;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/lsu_bus_ctrl_load_adj.sv
// Load-side lane adjuster: picks the addressed byte/half/word from a big-endian
// bus word, reorders it little-endian and sign- or zero-extends it.
module load_adj
   import srv1_lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [2:0]  fn3,
   input  logic [1:0]  addr_low,
   output logic [31:0] data
);

   logic [31:0] byte_sh;
   logic [31:0] half_sh;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] word_sel;

   always_comb begin
      // Shifting the addressed lane to the top avoids a variable part-select.
      byte_sh  = rdata << {addr_low, 3'b000};
      half_sh  = rdata << {addr_low[1], 4'b0000};
      byte_sel = byte_sh[31:24];
      half_sel = {half_sh[23:16], half_sh[31:24]};
      word_sel = {rdata[7:0], rdata[15:8], rdata[23:16], rdata[31:24]};
      case (fn3)
         FN3_B:   data = {{24{byte_sel[7]}}, byte_sel};
         FN3_H:   data = {{16{half_sel[15]}}, half_sel};
         FN3_W:   data = word_sel;
         FN3_BU:  data = {24'h000000, byte_sel};
         FN3_HU:  data = {16'h0000, half_sel};
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Single-outstanding load/store controller for the SRV1 memory stage:
// misalignment filter, req/ack bus handshake with timeout, load result adjust.
module lsu_bus_ctrl
   import srv1_lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        lsu_valid,
   input  logic        lsu_we,
   input  logic [2:0]  lsu_fn3,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] st_data,
   input  logic [3:0]  st_mask,
   output logic        lsu_ready,
   output logic        lsu_done,
   output logic [31:0] lsu_rdata,
   output logic        lsu_err,
   output logic        lsu_misalign,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_ack,
   input  logic        bus_err,
   input  logic [31:0] bus_rdata
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   state_e        state_q, state_d;
   logic [31:0]   addr_q, addr_d;
   logic          we_q, we_d;
   logic [2:0]    fn3_q, fn3_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    be_q, be_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic          mis_q, mis_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   load_data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         fn3_q   <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         mis_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         fn3_q   <= fn3_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         mis_q   <= mis_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      fn3_d   = fn3_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      mis_d   = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            // mis_q blocks re-acceptance while the held op's misalign pulse is out
            if (lsu_valid && !mis_q) begin
               addr_d  = lsu_addr;
               we_d    = lsu_we;
               fn3_d   = lsu_fn3;
               wdata_d = st_data;
               be_d    = lsu_we ? st_mask : load_be(lsu_fn3, lsu_addr[1:0]);
               if (is_misaligned(lsu_fn3, lsu_addr[1:0])) begin
                  mis_d = 1'b1;
               end else begin
                  state_d = REQ;
                  cnt_d   = '0;
                  err_d   = 1'b0;
                  rdata_d = '0;
               end
            end
         end
         REQ: begin
            if (bus_ack) begin
               rdata_d = bus_rdata;
               err_d   = bus_err;
               state_d = RESP;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   load_adj u_load_adj (
      .rdata    (rdata_q),
      .fn3      (fn3_q),
      .addr_low (addr_q[1:0]),
      .data     (load_data)
   );

   always_comb begin
      lsu_ready    = (state_q == IDLE) && !mis_q;
      lsu_misalign = mis_q;
      lsu_done     = (state_q == RESP) || mis_q;
      lsu_err      = (state_q == RESP) && err_q;
      lsu_rdata    = ((state_q == RESP) && !we_q && !err_q) ? load_data : '0;
      bus_req      = (state_q == REQ);
      bus_we       = bus_req && we_q;
      bus_addr     = bus_req ? {addr_q[31:2], 2'b00} : '0;
      bus_wdata    = bus_req ? wdata_q : '0;
      bus_be       = bus_req ? be_q : BE_NONE;
   end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed bench for lsu_bus_ctrl with a short timeout so the abort path is reachable.
module tb_lsu_bus_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        lsu_valid;
   logic        lsu_we;
   logic [2:0]  lsu_fn3;
   logic [31:0] lsu_addr;
   logic [31:0] st_data;
   logic [3:0]  st_mask;
   logic        lsu_ready;
   logic        lsu_done;
   logic [31:0] lsu_rdata;
   logic        lsu_err;
   logic        lsu_misalign;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack;
   logic        bus_err;
   logic [31:0] bus_rdata;

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   lsu_bus_ctrl #(.TIMEOUT_CYCLES(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .lsu_valid    (lsu_valid),
      .lsu_we       (lsu_we),
      .lsu_fn3      (lsu_fn3),
      .lsu_addr     (lsu_addr),
      .st_data      (st_data),
      .st_mask      (st_mask),
      .lsu_ready    (lsu_ready),
      .lsu_done     (lsu_done),
      .lsu_rdata    (lsu_rdata),
      .lsu_err      (lsu_err),
      .lsu_misalign (lsu_misalign),
      .bus_req      (bus_req),
      .bus_we       (bus_we),
      .bus_addr     (bus_addr),
      .bus_wdata    (bus_wdata),
      .bus_be       (bus_be),
      .bus_ack      (bus_ack),
      .bus_err      (bus_err),
      .bus_rdata    (bus_rdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one aligned op and answers it; ack_en=0 leaves the bus silent.
   task automatic run_op(input string tag, input logic we, input logic [2:0] fn3,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [3:0] sm,
                         input logic ack_en, input int unsigned waits,
                         input logic [31:0] rd, input logic berr,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int unsigned exp_req);
      int unsigned edges = 0;
      int unsigned req_cnt = 0;
      logic        done_seen = 1'b0;
      logic        unstable = 1'b0;
      logic [31:0] a0 = '0, w0 = '0;
      logic [3:0]  be0 = '0;
      logic        we0 = 1'b0;
      logic [31:0] rdata_at_done = '0;
      logic        err_at_done = 1'b0;
      lsu_valid = 1'b1;
      lsu_we    = we;
      lsu_fn3   = fn3;
      lsu_addr  = addr;
      st_data   = sd;
      st_mask   = sm;
      while (edges < 60) begin
         step();
         edges++;
         if (lsu_done) begin
            done_seen     = 1'b1;
            rdata_at_done = lsu_rdata;
            err_at_done   = lsu_err;
            break;
         end
         bus_ack = 1'b0;
         bus_err = 1'b0;
         if (bus_req) begin
            req_cnt++;
            if (req_cnt == 1) begin
               a0 = bus_addr; w0 = bus_wdata; be0 = bus_be; we0 = bus_we;
            end else if (bus_addr !== a0 || bus_wdata !== w0 || bus_be !== be0 || bus_we !== we0) begin
               unstable = 1'b1;
            end
            if (ack_en && req_cnt > waits) begin
               bus_ack   = 1'b1;
               bus_err   = berr;
               bus_rdata = rd;
            end
         end
      end
      bus_ack   = 1'b0;
      bus_err   = 1'b0;
      lsu_valid = 1'b0;
      check({tag, " done"}, 32'(done_seen), 32'd1);
      check({tag, " latency"}, edges, ack_en ? waits + 2 : exp_req + 1);
      check({tag, " req_cycles"}, req_cnt, exp_req);
      check({tag, " bus_addr"}, a0, {addr[31:2], 2'b00});
      check({tag, " bus_be"}, 32'(be0), 32'(exp_be));
      check({tag, " bus_we"}, 32'(we0), 32'(we));
      check({tag, " bus_wdata"}, w0, exp_wdata);
      check({tag, " stable"}, 32'(unstable), 32'd0);
      check({tag, " rdata"}, rdata_at_done, exp_rdata);
      check({tag, " err"}, 32'(err_at_done), 32'(exp_err));
      step();
      check({tag, " done_once"}, 32'(lsu_done), 32'd0);
      check({tag, " ready_after"}, 32'(lsu_ready), 32'd1);
   endtask

   task automatic run_mis(input string tag, input logic we, input logic [2:0] fn3,
                          input logic [31:0] addr);
      lsu_valid = 1'b1;
      lsu_we    = we;
      lsu_fn3   = fn3;
      lsu_addr  = addr;
      st_data   = 32'hDEADBEEF;
      st_mask   = 4'b1111;
      step();
      check({tag, " misalign"}, 32'(lsu_misalign), 32'd1);
      check({tag, " done"}, 32'(lsu_done), 32'd1);
      check({tag, " ready"}, 32'(lsu_ready), 32'd0);
      check({tag, " req"}, 32'(bus_req), 32'd0);
      step();
      lsu_valid = 1'b0;
      check({tag, " misalign_pulse"}, 32'(lsu_misalign), 32'd0);
      check({tag, " done_pulse"}, 32'(lsu_done), 32'd0);
      check({tag, " ready_back"}, 32'(lsu_ready), 32'd1);
      check({tag, " req_after"}, 32'(bus_req), 32'd0);
      step();
   endtask

   initial begin
      rst_n     = 1'b0;
      lsu_valid = 1'b0;
      lsu_we    = 1'b0;
      lsu_fn3   = 3'd0;
      lsu_addr  = '0;
      st_data   = '0;
      st_mask   = '0;
      bus_ack   = 1'b0;
      bus_err   = 1'b0;
      bus_rdata = '0;
      step();
      step();
      rst_n = 1'b1;
      check("rst ready", 32'(lsu_ready), 32'd1);
      check("rst done", 32'(lsu_done), 32'd0);
      check("rst req", 32'(bus_req), 32'd0);
      check("rst rdata", lsu_rdata, 32'd0);
      check("rst misalign", 32'(lsu_misalign), 32'd0);
      check("rst be", 32'(bus_be), 32'd0);
      step();

      run_op("ldB",  1'b0, 3'd0, 32'h0000_1001, '0, 4'b0000, 1'b1, 0, 32'h11F2_3344, 1'b0,
             4'b0100, 32'h0, 32'hFFFF_FFF2, 1'b0, 1);
      run_op("ldHU", 1'b0, 3'd5, 32'h0000_2002, '0, 4'b0000, 1'b1, 0, 32'hAABB_CCDD, 1'b0,
             4'b0011, 32'h0, 32'h0000_DDCC, 1'b0, 1);
      run_op("ldW",  1'b0, 3'd2, 32'h0000_2000, '0, 4'b0000, 1'b1, 0, 32'hAABB_CCDD, 1'b0,
             4'b1111, 32'h0, 32'hDDCC_BBAA, 1'b0, 1);
      run_op("ldH",  1'b0, 3'd1, 32'h0000_7000, '0, 4'b0000, 1'b1, 1, 32'h80FF_1234, 1'b0,
             4'b1100, 32'h0, 32'hFFFF_FF80, 1'b0, 2);
      run_op("ldBU", 1'b0, 3'd4, 32'h0000_7003, '0, 4'b0000, 1'b1, 0, 32'h80FF_1234, 1'b0,
             4'b0001, 32'h0, 32'h0000_0034, 1'b0, 1);
      run_op("stW",  1'b1, 3'd2, 32'h0000_3000, 32'h7856_3412, 4'b1111, 1'b1, 5, 32'hFFFF_FFFF, 1'b0,
             4'b1111, 32'h7856_3412, 32'h0, 1'b0, 6);

      run_mis("misH",  1'b0, 3'd1, 32'h0000_4001);
      run_mis("misW",  1'b1, 3'd2, 32'h0000_4002);
      run_mis("illeg", 1'b0, 3'd3, 32'h0000_4000);

      run_op("tmo",  1'b0, 3'd2, 32'h0000_5000, '0, 4'b0000, 1'b0, 0, 32'h1234_5678, 1'b0,
             4'b1111, 32'h0, 32'h0, 1'b1, 8);
      run_op("berr", 1'b0, 3'd4, 32'h0000_6003, '0, 4'b0000, 1'b1, 0, 32'h0000_00FF, 1'b1,
             4'b0001, 32'h0, 32'h0, 1'b1, 1);

      bus_ack   = 1'b1;
      bus_rdata = 32'hCAFE_F00D;
      step();
      step();
      bus_ack = 1'b0;
      check("idle_ack done", 32'(lsu_done), 32'd0);
      check("idle_ack req", 32'(bus_req), 32'd0);

      lsu_valid = 1'b1;
      lsu_we    = 1'b0;
      lsu_fn3   = 3'd2;
      lsu_addr  = 32'h0000_8000;
      step();
      check("rstmid req", 32'(bus_req), 32'd1);
      rst_n     = 1'b0;
      lsu_valid = 1'b0;
      step();
      check("rstmid req_drop", 32'(bus_req), 32'd0);
      check("rstmid ready", 32'(lsu_ready), 32'd1);
      check("rstmid done", 32'(lsu_done), 32'd0);
      rst_n = 1'b1;
      step();
      check("rstmid done2", 32'(lsu_done), 32'd0);
      run_op("postrst", 1'b0, 3'd0, 32'h0000_9002, '0, 4'b0000, 1'b1, 0, 32'h0102_8304, 1'b0,
             4'b0010, 32'h0, 32'hFFFF_FF83, 1'b0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
